// File: rtl/fifo_param_flags_if.sv
// fifo_param_flags_if
//   Bundles the producer/consumer-facing signals of fifo_param_flags.
//   master: the client side (drives requests, observes data and flags).
//   slave : the FIFO side (observes requests, drives data and flags).
//   Signals:
//     enable_write / value_to_write : write request and data
//     enable_read                   : read request
//     flush / clr_err               : synchronous clear of contents / error flags
//     value_to_read / read_valid    : registered read data and its strobe
//     full/empty/almost_full/almost_empty, count : occupancy status
//     overflow / underflow          : sticky error flags
interface fifo_param_flags_if #(
  parameter int BIT_DEPTH   = 8,
  parameter int FIFO_VOLUME = 8
);
  localparam int CNT_W = $clog2(FIFO_VOLUME + 1);

  logic                 enable_write;
  logic [BIT_DEPTH-1:0] value_to_write;
  logic                 enable_read;
  logic                 flush;
  logic                 clr_err;
  logic [BIT_DEPTH-1:0] value_to_read;
  logic                 read_valid;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [CNT_W-1:0]     count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output enable_write, value_to_write, enable_read, flush, clr_err,
    input  value_to_read, read_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  enable_write, value_to_write, enable_read, flush, clr_err,
    output value_to_read, read_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param_flags.sv
// fifo_param_flags
//   Single-clock FIFO with parametrised width, depth and almost thresholds.
//   Registered read data, registered flags, separate occupancy counter,
//   synchronous flush and sticky overflow/underflow flags.
//   Ports:
//     clk  : clock, all state changes on the rising edge
//     rst  : asynchronous active-low reset
//     bus  : fifo_param_flags_if.slave (requests in, data/flags out)
module fifo_param_flags #(
  parameter int BIT_DEPTH        = 8,
  parameter int FIFO_VOLUME      = 8,
  parameter int ALMOST_FULL_LVL  = FIFO_VOLUME - 2,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input  logic                clk,
  input  logic                rst,
  fifo_param_flags_if.slave   bus
);
  localparam int CNT_W = $clog2(FIFO_VOLUME + 1);
  localparam int IDX_W = $clog2(FIFO_VOLUME);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIFO_VOLUME - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_VOLUME);

  logic [BIT_DEPTH-1:0] mem [FIFO_VOLUME];
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic [CNT_W-1:0]     count_q, count_nxt;
  logic                 full_q, empty_q, af_q, ae_q;
  logic [BIT_DEPTH-1:0] rdata_q;
  logic                 rvalid_q;
  logic                 ovf_q, udf_q;

  logic rd_ok, wr_ok, do_rd, do_wr;

  // Acceptance follows the occupancy flags; a write into a full FIFO is
  // allowed only when a read frees a slot on the same edge.
  assign rd_ok = bus.enable_read & ~empty_q;
  assign wr_ok = bus.enable_write & (~full_q | rd_ok);
  // Flush suppresses the actual transfers but not the error evaluation.
  assign do_rd = rd_ok & ~bus.flush;
  assign do_wr = wr_ok & ~bus.flush;

  // NOTE: every variable assigned in always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count_q;
    if (bus.flush) begin
      count_nxt = '0;
    end else begin
      unique case ({do_wr, do_rd})
        2'b10:   count_nxt = count_q + 1'b1;
        2'b01:   count_nxt = count_q - 1'b1;
        default: count_nxt = count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through rd_idx after a write, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_idx] <= bus.value_to_write;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_idx <= '0;
        rd_idx <= '0;
      end else begin
        // Explicit wrap so non-power-of-two depths work.
        if (do_wr) wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
        if (do_rd) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      end
      if (do_rd) rdata_q <= mem[rd_idx];
      rvalid_q <= do_rd;

      count_q <= count_nxt;
      full_q  <= (count_nxt == FULL_CNT);
      empty_q <= (count_nxt == '0);
      af_q    <= (int'(count_nxt) >= ALMOST_FULL_LVL);
      ae_q    <= (int'(count_nxt) <= ALMOST_EMPTY_LVL);

      // A new error on the same edge as clr_err keeps the flag set.
      ovf_q <= (bus.enable_write & ~wr_ok) | (ovf_q & ~bus.clr_err);
      udf_q <= (bus.enable_read  & ~rd_ok) | (udf_q & ~bus.clr_err);
    end
  end

  assign bus.value_to_read = rdata_q;
  assign bus.read_valid    = rvalid_q;
  assign bus.count         = count_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.almost_full   = af_q;
  assign bus.almost_empty  = ae_q;
  assign bus.overflow      = ovf_q;
  assign bus.underflow     = udf_q;
endmodule
